reaction_session_ctrl: RTL and testbench

Sequencing controller for the reaction-timer datapath: random-delay up-counter, 1 kHz BCD millisecond timer, fixed hold up-counter, and seven-segment display. It runs a session of `ROUNDS` reaction trials, detects false starts, captures each reaction time and tracks the best (minimum) time. It sits between the debounced button logic and the counter/BCD instances in the top level, replacing ad-hoc per-state enable wiring.

---
 rtl/reaction_pkg.sv | 56 +++++
 rtl/reaction_session_ctrl_best.sv | 45 ++++
 rtl/reaction_session_ctrl.sv | 149 ++++++++++++++
 tb/tb_reaction_session_ctrl.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/reaction_pkg.sv
// Shared definitions for the reaction-timer session controller.
//   bcd_t    : four packed BCD digits
//   state_t  : FSM states, encoded with their state_leds codes
//   ctrl_t   : per-state datapath enables and status flags
//   decode() : state -> ctrl_t lookup used to register the outputs
package reaction_pkg;

  localparam logic [15:0] BCD_MAX = 16'h9999;

  typedef logic [15:0] bcd_t;

  // The encodings double as the state_leds pattern shown to the user.
  typedef enum logic [2:0] {
    S_IDLE   = 3'b000,
    S_ARM    = 3'b010,
    S_GO     = 3'b100,
    S_RESULT = 3'b110,
    S_FAULT  = 3'b001,
    S_DONE   = 3'b111
  } state_t;

  typedef struct packed {
    logic delay_en;
    logic hold_en;
    logic timer_en;
    logic timer_clr;
    logic led;
    logic false_start;
    logic session_done;
  } ctrl_t;

  function automatic ctrl_t decode(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S_IDLE:   c.timer_clr    = 1'b1;
      S_ARM:    begin
                  c.delay_en   = 1'b1;
                  c.timer_clr  = 1'b1;
                end
      S_GO:     begin
                  c.timer_en   = 1'b1;
                  c.led        = 1'b1;
                end
      S_RESULT: c.hold_en      = 1'b1;
      S_FAULT:  begin
                  c.hold_en     = 1'b1;
                  c.false_start = 1'b1;
                end
      S_DONE:   c.session_done = 1'b1;
      default:  c.timer_clr    = 1'b1;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/reaction_session_ctrl_best.sv
// bcd_best_tracker: keeps the fastest (minimum) valid reaction time.
//   Clk, Reset  : clock, asynchronous active-high reset
//   clear       : new session, best_time <= BCD_MAX, best_valid <= 0
//   invalidate  : session aborted, best_valid <= 0, best_time kept
//   capture     : a reaction time is being latched this cycle
//   miss        : the captured value is a timeout, never a candidate
//   time_in     : value being captured
//   best_time   : best time so far (BCD), best_valid : best_time is real
module bcd_best_tracker
  import reaction_pkg::*;
#(
  parameter bcd_t BCD_MAX = reaction_pkg::BCD_MAX
) (
  input  logic Clk,
  input  logic Reset,
  input  logic clear,
  input  logic invalidate,
  input  logic capture,
  input  logic miss,
  input  bcd_t time_in,
  output bcd_t best_time,
  output logic best_valid
);

  // Every nibble is 0..9, so plain unsigned compare orders BCD correctly.
  // Strict less-than: a tie keeps the earlier best.
  logic better;
  assign better = capture && !miss && (time_in < best_time);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      best_time  <= BCD_MAX;
      best_valid <= 1'b0;
    end else if (clear) begin
      best_time  <= BCD_MAX;
      best_valid <= 1'b0;
    end else if (invalidate) begin
      best_valid <= 1'b0;
    end else if (better) begin
      best_time  <= time_in;
      best_valid <= 1'b1;
    end
  end

endmodule

// File: rtl/reaction_session_ctrl.sv
// reaction_session_ctrl: sequences a session of ROUNDS reaction trials.
//   Clk, Reset               : clock, asynchronous active-high reset
//   start_p, react_p, abort_p: one-cycle debounced button pulses
//   delay_done, hold_done    : levels from the delay / hold counters
//   timer_bcd                : live BCD millisecond timer
//   delay_en, hold_en,
//   timer_en, timer_clr      : datapath counter controls
//   led                      : "react now" stimulus
//   state_leds               : state code
//   round_num                : 1..ROUNDS during a session, 0 in IDLE
//   last_time, best_time     : captured / best reaction time (BCD)
//   best_valid, false_start,
//   session_done             : status flags
// All outputs are registered.
module reaction_session_ctrl
  import reaction_pkg::*;
#(
  parameter int   ROUNDS  = 5,
  parameter bcd_t BCD_MAX = reaction_pkg::BCD_MAX
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        start_p,
  input  logic        react_p,
  input  logic        abort_p,
  input  logic        delay_done,
  input  logic        hold_done,
  input  logic [15:0] timer_bcd,
  output logic        delay_en,
  output logic        hold_en,
  output logic        timer_en,
  output logic        timer_clr,
  output logic        led,
  output logic [2:0]  state_leds,
  output logic [3:0]  round_num,
  output logic [15:0] last_time,
  output logic [15:0] best_time,
  output logic        best_valid,
  output logic        false_start,
  output logic        session_done
);

  localparam logic [3:0] LAST_ROUND = 4'(ROUNDS);

  state_t     state, state_next;
  logic [3:0] round_next;
  logic       first_cycle;    // high during the first cycle in any state
  logic       capture;        // GO -> RESULT, last_time latches timer_bcd
  logic       start_session;  // IDLE/DONE -> ARM
  logic       saturated;
  ctrl_t      ctrl;

  assign saturated = (timer_bcd == BCD_MAX);

  // Counter done levels can still be high from the previous use in the
  // cycle an enable rises, so they only count once first_cycle drops.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    state_next    = state;
    round_next    = round_num;
    capture       = 1'b0;
    start_session = 1'b0;
    if (abort_p) begin
      state_next = S_IDLE;
      round_next = 4'd0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start_p) begin
            state_next    = S_ARM;
            round_next    = 4'd1;
            start_session = 1'b1;
          end
        end
        S_ARM: begin
          if (react_p)                         state_next = S_FAULT;
          else if (delay_done && !first_cycle) state_next = S_GO;
        end
        S_GO: begin
          // react_p outranks saturation, but both latch timer_bcd.
          if (react_p || saturated) begin
            capture    = 1'b1;
            state_next = S_RESULT;
          end
        end
        S_RESULT: begin
          if (hold_done && !first_cycle) begin
            if (round_num == LAST_ROUND) begin
              state_next = S_DONE;
            end else begin
              state_next = S_ARM;
              round_next = round_num + 4'd1;
            end
          end
        end
        S_FAULT: begin
          // A false start repeats the round; round_num is left alone.
          if (hold_done && !first_cycle) state_next = S_ARM;
        end
        default: state_next = S_IDLE;
      endcase
    end
  end

  // Outputs are decoded from the next state and registered, so they move
  // on the same edge as the state they belong to.
  always_ff @(posedge Clk or posedge Reset) begin
    // NOTE: sequential state uses non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    if (Reset) begin
      state       <= S_IDLE;
      first_cycle <= 1'b1;
      round_num   <= 4'd0;
      last_time   <= 16'h0000;
      ctrl        <= decode(S_IDLE);
    end else begin
      state       <= state_next;
      first_cycle <= (state_next != state);
      round_num   <= round_next;
      ctrl        <= decode(state_next);
      if (capture) last_time <= timer_bcd;
    end
  end

  bcd_best_tracker #(
    .BCD_MAX (BCD_MAX)
  ) u_best (
    .Clk        (Clk),
    .Reset      (Reset),
    .clear      (start_session),
    .invalidate (abort_p),
    .capture    (capture),
    .miss       (saturated),
    .time_in    (timer_bcd),
    .best_time  (best_time),
    .best_valid (best_valid)
  );

  assign state_leds   = state;
  assign delay_en     = ctrl.delay_en;
  assign hold_en      = ctrl.hold_en;
  assign timer_en     = ctrl.timer_en;
  assign timer_clr    = ctrl.timer_clr;
  assign led          = ctrl.led;
  assign false_start  = ctrl.false_start;
  assign session_done = ctrl.session_done;

endmodule

// File: tb/tb_reaction_session_ctrl.sv
// Bench for reaction_session_ctrl with ROUNDS=3: one table row per clock,
// plus hand-written abort and asynchronous-reset sequences.
module tb_reaction_session_ctrl;

  localparam logic [2:0] ST_IDLE = 3'b000, ST_ARM = 3'b010, ST_GO = 3'b100,
                         ST_RES  = 3'b110, ST_FLT = 3'b001, ST_DONE = 3'b111;
  // {delay_en, hold_en, timer_en, timer_clr, led}
  localparam logic [4:0] EN_IDLE = 5'b00010, EN_ARM = 5'b10010,
                         EN_GO   = 5'b00101, EN_HOLD = 5'b01000,
                         EN_DONE = 5'b00000;

  logic        Clk, Reset;
  logic        start_p, react_p, abort_p, delay_done, hold_done;
  logic [15:0] timer_bcd;
  logic        delay_en, hold_en, timer_en, timer_clr, led;
  logic [2:0]  state_leds;
  logic [3:0]  round_num;
  logic [15:0] last_time, best_time;
  logic        best_valid, false_start, session_done;

  reaction_session_ctrl #(.ROUNDS(3), .BCD_MAX(16'h9999)) dut (
    .Clk(Clk), .Reset(Reset),
    .start_p(start_p), .react_p(react_p), .abort_p(abort_p),
    .delay_done(delay_done), .hold_done(hold_done), .timer_bcd(timer_bcd),
    .delay_en(delay_en), .hold_en(hold_en), .timer_en(timer_en),
    .timer_clr(timer_clr), .led(led), .state_leds(state_leds),
    .round_num(round_num), .last_time(last_time), .best_time(best_time),
    .best_valid(best_valid), .false_start(false_start),
    .session_done(session_done)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic        st, rk, ab, dd, hd;
    logic [15:0] tb;
    logic [2:0]  sl;
    logic [3:0]  rn;
    logic [4:0]  en;
    logic [15:0] lt, bt;
    logic        bv, fs, sd;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic st, rk, ab, dd, hd, input logic [15:0] tb,
                     input logic [2:0] sl, input logic [3:0] rn,
                     input logic [4:0] en, input logic [15:0] lt, bt,
                     input logic bv, fs, sd);
    vec_t v;
    v.st = st; v.rk = rk; v.ab = ab; v.dd = dd; v.hd = hd; v.tb = tb;
    v.sl = sl; v.rn = rn; v.en = en; v.lt = lt; v.bt = bt;
    v.bv = bv; v.fs = fs; v.sd = sd;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic st, rk, ab, dd, hd, input logic [15:0] tb);
    start_p = st; react_p = rk; abort_p = ab;
    delay_done = dd; hold_done = hd; timer_bcd = tb;
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic [2:0] sl,
                           input logic [3:0] rn, input logic [4:0] en,
                           input logic [15:0] lt, bt,
                           input logic bv, fs, sd);
    check({tag, ".state"},  32'(state_leds), 32'(sl));
    check({tag, ".round"},  32'(round_num), 32'(rn));
    check({tag, ".enables"},
          32'({delay_en, hold_en, timer_en, timer_clr, led}), 32'(en));
    check({tag, ".last"},   32'(last_time), 32'(lt));
    check({tag, ".best"},   32'(best_time), 32'(bt));
    check({tag, ".flags"},  32'({best_valid, false_start, session_done}),
          32'({bv, fs, sd}));
  endtask

  initial begin
    //   st rk ab dd hd tb        | sl       rn  en       last     best   bv fs sd
    // Session 1: normal round, stale-level guards, false start, miss.
    add(1,0,0,0,0,16'h0000, ST_ARM, 1, EN_ARM,  16'h0000,16'h9999,0,0,0);
    add(0,0,0,1,0,16'h0000, ST_ARM, 1, EN_ARM,  16'h0000,16'h9999,0,0,0);
    add(0,0,0,1,0,16'h0000, ST_GO,  1, EN_GO,   16'h0000,16'h9999,0,0,0);
    add(0,0,0,0,0,16'h0100, ST_GO,  1, EN_GO,   16'h0000,16'h9999,0,0,0);
    add(0,1,0,0,0,16'h0245, ST_RES, 1, EN_HOLD, 16'h0245,16'h0245,1,0,0);
    add(0,0,0,0,1,16'h0000, ST_RES, 1, EN_HOLD, 16'h0245,16'h0245,1,0,0);
    add(0,0,0,0,1,16'h0000, ST_ARM, 2, EN_ARM,  16'h0245,16'h0245,1,0,0);
    add(0,1,0,0,0,16'h0000, ST_FLT, 2, EN_HOLD, 16'h0245,16'h0245,1,1,0);
    add(0,0,0,0,1,16'h0000, ST_FLT, 2, EN_HOLD, 16'h0245,16'h0245,1,1,0);
    add(0,0,0,0,1,16'h0000, ST_ARM, 2, EN_ARM,  16'h0245,16'h0245,1,0,0);
    add(0,0,0,0,0,16'h0000, ST_ARM, 2, EN_ARM,  16'h0245,16'h0245,1,0,0);
    add(0,0,0,1,0,16'h0000, ST_GO,  2, EN_GO,   16'h0245,16'h0245,1,0,0);
    add(0,1,0,0,0,16'h0199, ST_RES, 2, EN_HOLD, 16'h0199,16'h0199,1,0,0);
    add(0,0,0,0,0,16'h0000, ST_RES, 2, EN_HOLD, 16'h0199,16'h0199,1,0,0);
    add(0,0,0,0,1,16'h0000, ST_ARM, 3, EN_ARM,  16'h0199,16'h0199,1,0,0);
    add(0,0,0,0,0,16'h0000, ST_ARM, 3, EN_ARM,  16'h0199,16'h0199,1,0,0);
    add(0,0,0,1,0,16'h0000, ST_GO,  3, EN_GO,   16'h0199,16'h0199,1,0,0);
    add(0,0,0,0,0,16'h9999, ST_RES, 3, EN_HOLD, 16'h9999,16'h0199,1,0,0);
    add(0,0,0,0,0,16'h0000, ST_RES, 3, EN_HOLD, 16'h9999,16'h0199,1,0,0);
    add(0,0,0,0,1,16'h0000, ST_DONE,3, EN_DONE, 16'h9999,16'h0199,1,0,1);
    add(0,1,0,0,0,16'h0000, ST_DONE,3, EN_DONE, 16'h9999,16'h0199,1,0,1);
    // Session 2 from DONE: times 0300 / 0199 / 0250.
    add(1,0,0,0,0,16'h0000, ST_ARM, 1, EN_ARM,  16'h9999,16'h9999,0,0,0);
    add(0,0,0,0,0,16'h0000, ST_ARM, 1, EN_ARM,  16'h9999,16'h9999,0,0,0);
    add(0,0,0,1,0,16'h0000, ST_GO,  1, EN_GO,   16'h9999,16'h9999,0,0,0);
    add(0,1,0,0,0,16'h0300, ST_RES, 1, EN_HOLD, 16'h0300,16'h0300,1,0,0);
    add(0,0,0,0,0,16'h0000, ST_RES, 1, EN_HOLD, 16'h0300,16'h0300,1,0,0);
    add(0,0,0,0,1,16'h0000, ST_ARM, 2, EN_ARM,  16'h0300,16'h0300,1,0,0);
    add(0,0,0,0,0,16'h0000, ST_ARM, 2, EN_ARM,  16'h0300,16'h0300,1,0,0);
    add(0,0,0,1,0,16'h0000, ST_GO,  2, EN_GO,   16'h0300,16'h0300,1,0,0);
    add(0,1,0,0,0,16'h0199, ST_RES, 2, EN_HOLD, 16'h0199,16'h0199,1,0,0);
    add(0,0,0,0,0,16'h0000, ST_RES, 2, EN_HOLD, 16'h0199,16'h0199,1,0,0);
    add(0,0,0,0,1,16'h0000, ST_ARM, 3, EN_ARM,  16'h0199,16'h0199,1,0,0);
    add(0,0,0,0,0,16'h0000, ST_ARM, 3, EN_ARM,  16'h0199,16'h0199,1,0,0);
    add(0,0,0,1,0,16'h0000, ST_GO,  3, EN_GO,   16'h0199,16'h0199,1,0,0);
    add(0,1,0,0,0,16'h0250, ST_RES, 3, EN_HOLD, 16'h0250,16'h0199,1,0,0);
    add(0,0,0,0,0,16'h0000, ST_RES, 3, EN_HOLD, 16'h0250,16'h0199,1,0,0);
    add(0,0,0,0,1,16'h0000, ST_DONE,3, EN_DONE, 16'h0250,16'h0199,1,0,1);
    // Abort beats start in DONE; results are kept, flags cleared.
    add(1,0,1,0,0,16'h0000, ST_IDLE,0, EN_IDLE, 16'h0250,16'h0199,0,0,0);

    Reset = 1'b1;
    drive(0,0,0,0,0,16'h0000);
    tick();
    tick();
    check_all("reset", ST_IDLE, 0, EN_IDLE, 16'h0000, 16'h9999, 0, 0, 0);
    Reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].st, vecs[i].rk, vecs[i].ab, vecs[i].dd, vecs[i].hd,
            vecs[i].tb);
      tick();
      check_all($sformatf("vec%0d", i), vecs[i].sl, vecs[i].rn, vecs[i].en,
                vecs[i].lt, vecs[i].bt, vecs[i].bv, vecs[i].fs, vecs[i].sd);
    end

    // Abort and react together in GO: abort wins, last_time untouched.
    drive(1,0,0,0,0,16'h0000); tick();
    drive(0,0,0,0,0,16'h0000); tick();
    drive(0,0,0,1,0,16'h0000); tick();
    check("abort.pre_go", 32'(state_leds), 32'(ST_GO));
    drive(0,1,1,0,0,16'h0777); tick();
    check_all("abort", ST_IDLE, 0, EN_IDLE, 16'h0250, 16'h9999, 0, 0, 0);

    // Asynchronous reset mid-GO: values change with no clock edge.
    drive(1,0,0,0,0,16'h0000); tick();
    drive(0,0,0,0,0,16'h0000); tick();
    drive(0,0,0,1,0,16'h0000); tick();
    drive(0,0,0,0,0,16'h0123);
    check("areset.pre_led", 32'(led), 32'd1);
    #2 Reset = 1'b1;
    #1;
    check_all("areset", ST_IDLE, 0, EN_IDLE, 16'h0000, 16'h9999, 0, 0, 0);
    #1 Reset = 1'b0;
    tick();
    check_all("release", ST_IDLE, 0, EN_IDLE, 16'h0000, 16'h9999, 0, 0, 0);
    drive(1,0,0,0,0,16'h0000); tick();
    check("release.start", 32'(state_leds), 32'(ST_ARM));
    drive(0,0,0,0,0,16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
